palette_encoder: RTL and testbench

- Reverse of the sprite palette lookup: converts a streamed 12-bit RGB pixel into the 4-bit index of the nearest entry in a 16-entry palette.
- Used by the sprite-capture/recolour path to pack RGB frame data into 4-bit sprite ROM images.
- The palette is a writable register file, reset to the Player 1 palette.
- One pixel is in flight at a time. An iterative search compares one palette entry per cycle.

---
 rtl/palette_encoder_if.sv | 38 +++
 rtl/palette_encoder.sv | 192 +++++++++++++++++++
 tb/tb_palette_encoder.sv | 277 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/palette_encoder_if.sv
// ----------------------------------------------------------------------------
// palette_encoder_if
// Bundles the pixel-in, result-out and palette-write signals of
// palette_encoder.
//   pixel in  : in_valid, in_ready, in_red, in_green, in_blue (4 bit each)
//   result out: out_valid, out_ready, out_index (4), out_dist (6), out_transp
//   palette   : pal_we, pal_addr (4), pal_data (12, {R,G,B}), pal_ready
// The master modport is the pixel source / result sink / palette writer.
// The slave modport is the encoder.
// ----------------------------------------------------------------------------
interface palette_encoder_if;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_red;
  logic [3:0]  in_green;
  logic [3:0]  in_blue;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  out_index;
  logic [5:0]  out_dist;
  logic        out_transp;
  logic        pal_we;
  logic [3:0]  pal_addr;
  logic [11:0] pal_data;
  logic        pal_ready;

  modport master (
    output in_valid, in_red, in_green, in_blue, out_ready,
           pal_we, pal_addr, pal_data,
    input  in_ready, out_valid, out_index, out_dist, out_transp, pal_ready
  );

  modport slave (
    input  in_valid, in_red, in_green, in_blue, out_ready,
           pal_we, pal_addr, pal_data,
    output in_ready, out_valid, out_index, out_dist, out_transp, pal_ready
  );
endinterface

// File: rtl/palette_encoder.sv
// ----------------------------------------------------------------------------
// palette_encoder
// Converts one streamed 12-bit RGB pixel into the 4-bit index of the nearest
// (Manhattan distance) entry of a writable 16-entry palette. One pixel is in
// flight at a time; the search visits one palette entry per cycle, exits early
// on an exact match, and resolves ties to the lowest index.
//
// Ports:
//   Clk      : system clock, rising edge
//   Reset_n  : asynchronous active-low reset
//   bus      : palette_encoder_if.slave (pixel in, result out, palette write)
//
// Optional feature (macro PAL_ENC_TRANSP_KEY_EN): a pixel equal to KEY_COLOR
// bypasses the search and is reported as KEY_INDEX with out_transp=1.
// Without the macro out_transp is tied low.
// ----------------------------------------------------------------------------
module palette_encoder #(
  parameter int          NUM_ENTRIES = 16,
  parameter logic [11:0] KEY_COLOR   = 12'hF0B,
  parameter logic [3:0]  KEY_INDEX   = 4'd0
) (
  input  logic             Clk,
  input  logic             Reset_n,
  palette_encoder_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SEARCH = 2'd1,
    DONE   = 2'd2
  } state_t;

  localparam logic [3:0] LAST_IDX  = 4'(NUM_ENTRIES - 1);
  localparam logic [5:0] DIST_INIT = 6'd63;

  // Absolute difference of two unsigned 4-bit channels.
  function automatic logic [3:0] abs_diff(input logic [3:0] a, input logic [3:0] b);
    logic signed [4:0] diff;
    diff = $signed({1'b0, a}) - $signed({1'b0, b});
    return (diff < 0) ? 4'(-diff) : 4'(diff);
  endfunction

  // Manhattan distance between two {R,G,B} colours; max 45 fits 6 bits.
  function automatic logic [5:0] manhattan(input logic [11:0] p, input logic [11:0] q);
    return 6'(abs_diff(p[11:8], q[11:8])) +
           6'(abs_diff(p[7:4],  q[7:4]))  +
           6'(abs_diff(p[3:0],  q[3:0]));
  endfunction

  // Player 1 palette loaded at reset.
  function automatic logic [11:0] reset_entry(input int idx);
    case (idx)
      2:       return 12'hF00;
      3:       return 12'hFFF;
      4:       return 12'h941;
      5:       return 12'hFF0;
      7:       return 12'h000;
      default: return 12'hF0B;
    endcase
  endfunction

  state_t      r_state;
  state_t      w_next;
  logic [11:0] r_pal [NUM_ENTRIES];
  logic [11:0] r_pix;
  logic [3:0]  r_cnt;
  logic [5:0]  r_best_dist;
  logic [3:0]  r_best_idx;
  logic        r_out_valid;
  logic [3:0]  r_out_index;
  logic [5:0]  r_out_dist;

  logic [11:0] w_in_pix;
  logic [11:0] w_entry;
  logic [5:0]  w_dist;
  logic        w_better;
  logic        w_hit_end;
  logic        w_accept;
  logic        w_pal_wr;
  logic        w_is_key;

  assign w_in_pix  = {bus.in_red, bus.in_green, bus.in_blue};
  assign w_entry   = r_pal[r_cnt];
  assign w_dist    = manhattan(r_pix, w_entry);
  assign w_better  = (w_dist < r_best_dist);
  // Search ends on an exact match or after the last entry; cnt never wraps.
  assign w_hit_end = (w_dist == 6'd0) || (r_cnt == LAST_IDX);

  assign bus.in_ready  = (r_state == IDLE);
  assign bus.pal_ready = (r_state == IDLE);
  assign bus.out_valid = r_out_valid;
  assign bus.out_index = r_out_index;
  assign bus.out_dist  = r_out_dist;

`ifdef PAL_ENC_TRANSP_KEY_EN
  logic r_out_transp;
  assign w_is_key       = (w_in_pix == KEY_COLOR);
  assign bus.out_transp = r_out_transp;
`else
  // Key parameters have no effect in this build.
  logic w_unused_key;
  assign w_unused_key   = ^{KEY_COLOR, KEY_INDEX};
  assign w_is_key       = 1'b0;
  assign bus.out_transp = 1'b0;
`endif

  // ---- state register ----
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) r_state <= IDLE;
    else          r_state <= w_next;
  end

  // ---- next state / control ----
  always_comb begin
    w_next   = r_state;
    w_accept = 1'b0;
    w_pal_wr = 1'b0;
    case (r_state)
      IDLE: begin
        w_pal_wr = bus.pal_we;
        if (bus.in_valid) begin
          w_accept = 1'b1;
          w_next   = w_is_key ? DONE : SEARCH;
        end
      end
      SEARCH: if (w_hit_end)     w_next = DONE;
      DONE:   if (bus.out_ready) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // ---- palette register file ----
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      for (int i = 0; i < NUM_ENTRIES; i++) r_pal[i] <= reset_entry(i);
    end else if (w_pal_wr) begin
      r_pal[bus.pal_addr] <= bus.pal_data;
    end
  end

  // ---- search datapath and result registers ----
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_pix       <= 12'h000;
      r_cnt       <= 4'd0;
      r_best_dist <= DIST_INIT;
      r_best_idx  <= 4'd0;
      r_out_valid <= 1'b0;
      r_out_index <= 4'd0;
      r_out_dist  <= 6'd0;
    end else begin
      if (w_accept) begin
        r_pix       <= w_in_pix;
        r_cnt       <= 4'd0;
        r_best_dist <= DIST_INIT;
        r_best_idx  <= 4'd0;
        if (w_is_key) begin
          r_out_valid <= 1'b1;
          r_out_index <= KEY_INDEX;
          r_out_dist  <= 6'd0;
        end
      end
      if (r_state == SEARCH) begin
        if (w_better) begin
          r_best_dist <= w_dist;
          r_best_idx  <= r_cnt;
        end
        if (w_hit_end) begin
          // Fold this cycle's comparison into the published result.
          r_out_valid <= 1'b1;
          r_out_index <= w_better ? r_cnt  : r_best_idx;
          r_out_dist  <= w_better ? w_dist : r_best_dist;
        end else begin
          r_cnt <= r_cnt + 4'd1;
        end
      end
      if ((r_state == DONE) && bus.out_ready) r_out_valid <= 1'b0;
    end
  end

`ifdef PAL_ENC_TRANSP_KEY_EN
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_out_transp <= 1'b0;
    end else if (w_accept) begin
      // Non-key pixels clear the flag before their search completes.
      r_out_transp <= w_is_key;
    end
  end
`endif

endmodule

// File: tb/tb_palette_encoder.sv
// ----------------------------------------------------------------------------
// tb_palette_encoder
// Directed testbench for palette_encoder: reset, exact match, full search,
// tie-breaking, backpressure with blocked palette writes, simultaneous write
// and accept, and the transparency-key behaviour for the current build.
// ----------------------------------------------------------------------------
module tb_palette_encoder;
  logic Clk;
  logic Reset_n;
  int   total;
  int   bad;

  palette_encoder_if bus ();

  palette_encoder dut (
    .Clk     (Clk),
    .Reset_n (Reset_n),
    .bus     (bus.slave)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Presents one pixel (optionally with a palette write in the same cycle),
  // then counts cycles from the accept edge until out_valid is seen.
  // lat = -1 when the result never appears.
  task automatic send_pixel(input logic [11:0] rgb, input logic we,
                            input logic [3:0] a, input logic [11:0] d,
                            output int lat);
    @(negedge Clk);
    bus.in_red   = rgb[11:8];
    bus.in_green = rgb[7:4];
    bus.in_blue  = rgb[3:0];
    bus.in_valid = 1'b1;
    bus.pal_we   = we;
    bus.pal_addr = a;
    bus.pal_data = d;
    @(posedge Clk);
    #1;
    bus.in_valid = 1'b0;
    bus.pal_we   = 1'b0;
    lat = -1;
    for (int j = 1; j <= 40; j++) begin
      @(negedge Clk);
      if (bus.out_valid === 1'b1) begin
        lat = j;
        break;
      end
    end
  endtask

  task automatic pop_result();
    @(negedge Clk);
    bus.out_ready = 1'b1;
    @(posedge Clk);
    #1;
    bus.out_ready = 1'b0;
  endtask

  task automatic pal_write(input logic [3:0] a, input logic [11:0] d);
    @(negedge Clk);
    bus.pal_we   = 1'b1;
    bus.pal_addr = a;
    bus.pal_data = d;
    @(posedge Clk);
    #1;
    bus.pal_we = 1'b0;
  endtask

  task automatic test_reset();
    int lat;
    int seen;
    // power-on reset
    Reset_n = 1'b0;
    repeat (3) @(posedge Clk);
    #1;
    total++;
    if ({bus.in_ready, bus.out_valid, bus.out_index, bus.out_dist, bus.out_transp, bus.pal_ready}
        !== {1'b1, 1'b0, 4'd0, 6'd0, 1'b0, 1'b1}) begin
      bad++;
      $display("FAIL reset_por: got rdy=%b vld=%b idx=%0d dist=%0d tr=%b prdy=%b want 1 0 0 0 0 1",
               bus.in_ready, bus.out_valid, bus.out_index, bus.out_dist, bus.out_transp, bus.pal_ready);
    end
    @(negedge Clk);
    Reset_n = 1'b1;
    // start a long search, then reset it midway
    @(negedge Clk);
    bus.in_red = 4'hE; bus.in_green = 4'h1; bus.in_blue = 4'h1;
    bus.in_valid = 1'b1;
    @(posedge Clk);
    #1;
    bus.in_valid = 1'b0;
    repeat (5) @(negedge Clk);
    total++;
    if (bus.in_ready !== 1'b0) begin
      bad++;
      $display("FAIL reset_busy_rdy: got %b want 0", bus.in_ready);
    end
    Reset_n = 1'b0;
    #1;
    total++;
    if ({bus.in_ready, bus.out_valid, bus.out_index, bus.out_dist, bus.out_transp, bus.pal_ready}
        !== {1'b1, 1'b0, 4'd0, 6'd0, 1'b0, 1'b1}) begin
      bad++;
      $display("FAIL reset_mid_search: got rdy=%b vld=%b idx=%0d dist=%0d tr=%b prdy=%b want 1 0 0 0 0 1",
               bus.in_ready, bus.out_valid, bus.out_index, bus.out_dist, bus.out_transp, bus.pal_ready);
    end
    @(negedge Clk);
    Reset_n = 1'b1;
    seen = 0;
    for (int j = 0; j < 20; j++) begin
      @(negedge Clk);
      if (bus.out_valid === 1'b1) seen++;
    end
    total++;
    if (seen !== 0) begin
      bad++;
      $display("FAIL reset_abort: out_valid high %0d cycles want 0", seen);
    end
    send_pixel(12'h000, 1'b0, 4'd0, 12'h000, lat);
    total++;
    if ({bus.out_index, bus.out_dist} !== {4'd7, 6'd0} || lat !== 9) begin
      bad++;
      $display("FAIL reset_then_000: got idx=%0d dist=%0d lat=%0d want 7 0 9",
               bus.out_index, bus.out_dist, lat);
    end
    pop_result();
    @(negedge Clk);
    total++;
    if ({bus.out_valid, bus.in_ready, bus.out_index} !== {1'b0, 1'b1, 4'd7}) begin
      bad++;
      $display("FAIL handshake_fall: got vld=%b rdy=%b idx=%0d want 0 1 7",
               bus.out_valid, bus.in_ready, bus.out_index);
    end
  endtask

  task automatic test_exact_match();
    int lat;
    send_pixel(12'h941, 1'b0, 4'd0, 12'h000, lat);
    total++;
    if ({bus.out_index, bus.out_dist} !== {4'd4, 6'd0} || lat !== 6) begin
      bad++;
      $display("FAIL exact_941: got idx=%0d dist=%0d lat=%0d want 4 0 6",
               bus.out_index, bus.out_dist, lat);
    end
    pop_result();
  endtask

  task automatic test_full_search();
    int lat;
    send_pixel(12'hE11, 1'b0, 4'd0, 12'h000, lat);
    total++;
    if ({bus.out_index, bus.out_dist} !== {4'd2, 6'd3} || lat !== 17) begin
      bad++;
      $display("FAIL nearest_E11: got idx=%0d dist=%0d lat=%0d want 2 3 17",
               bus.out_index, bus.out_dist, lat);
    end
    pop_result();
  endtask

  task automatic test_tie();
    int lat;
    pal_write(4'd12, 12'hFFE);
    pal_write(4'd13, 12'hFFE);
    send_pixel(12'hFFC, 1'b0, 4'd0, 12'h000, lat);
    total++;
    if ({bus.out_index, bus.out_dist} !== {4'd12, 6'd2} || lat !== 17) begin
      bad++;
      $display("FAIL tie_FFC: got idx=%0d dist=%0d lat=%0d want 12 2 17",
               bus.out_index, bus.out_dist, lat);
    end
    pop_result();
  endtask

  task automatic test_backpressure();
    int lat;
    int unstable;
    int prdy_bad;
    send_pixel(12'h941, 1'b0, 4'd0, 12'h000, lat);
    unstable = 0;
    prdy_bad = 0;
    bus.pal_we   = 1'b1;
    bus.pal_addr = 4'd3;
    bus.pal_data = 12'h123;
    for (int j = 0; j < 10; j++) begin
      @(negedge Clk);
      if ({bus.out_valid, bus.out_index, bus.out_dist, bus.in_ready} !== {1'b1, 4'd4, 6'd0, 1'b0})
        unstable++;
      if (bus.pal_ready !== 1'b0) prdy_bad++;
    end
    bus.pal_we = 1'b0;
    total++;
    if (unstable !== 0) begin
      bad++;
      $display("FAIL backpressure_hold: %0d unstable cycles want 0", unstable);
    end
    total++;
    if (prdy_bad !== 0) begin
      bad++;
      $display("FAIL pal_ready_done: high in %0d DONE cycles want 0", prdy_bad);
    end
    pop_result();
    send_pixel(12'hFFF, 1'b0, 4'd0, 12'h000, lat);
    total++;
    if ({bus.out_index, bus.out_dist} !== {4'd3, 6'd0} || lat !== 5) begin
      bad++;
      $display("FAIL blocked_write_FFF: got idx=%0d dist=%0d lat=%0d want 3 0 5",
               bus.out_index, bus.out_dist, lat);
    end
    pop_result();
  endtask

  task automatic test_write_and_pixel();
    int lat;
    send_pixel(12'h5A5, 1'b1, 4'd1, 12'h5A5, lat);
    total++;
    if ({bus.out_index, bus.out_dist} !== {4'd1, 6'd0} || lat !== 3) begin
      bad++;
      $display("FAIL write_with_pixel: got idx=%0d dist=%0d lat=%0d want 1 0 3",
               bus.out_index, bus.out_dist, lat);
    end
    pop_result();
  endtask

  task automatic test_key_color();
    int lat;
    send_pixel(12'hF0B, 1'b0, 4'd0, 12'h000, lat);
`ifdef PAL_ENC_TRANSP_KEY_EN
    total++;
    if ({bus.out_transp, bus.out_index, bus.out_dist} !== {1'b1, 4'd0, 6'd0} || lat !== 1) begin
      bad++;
      $display("FAIL key_F0B: got tr=%b idx=%0d dist=%0d lat=%0d want 1 0 0 1",
               bus.out_transp, bus.out_index, bus.out_dist, lat);
    end
`else
    total++;
    if ({bus.out_transp, bus.out_index, bus.out_dist} !== {1'b0, 4'd0, 6'd0} || lat !== 2) begin
      bad++;
      $display("FAIL key_F0B: got tr=%b idx=%0d dist=%0d lat=%0d want 0 0 0 2",
               bus.out_transp, bus.out_index, bus.out_dist, lat);
    end
`endif
    pop_result();
    // an ordinary pixel after the key pixel never reports transparency
    send_pixel(12'hFF0, 1'b0, 4'd0, 12'h000, lat);
    total++;
    if ({bus.out_transp, bus.out_index, bus.out_dist} !== {1'b0, 4'd5, 6'd0} || lat !== 7) begin
      bad++;
      $display("FAIL after_key_FF0: got tr=%b idx=%0d dist=%0d lat=%0d want 0 5 0 7",
               bus.out_transp, bus.out_index, bus.out_dist, lat);
    end
    pop_result();
  endtask

  initial begin
    total = 0;
    bad   = 0;
    Reset_n       = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_red    = 4'h0;
    bus.in_green  = 4'h0;
    bus.in_blue   = 4'h0;
    bus.out_ready = 1'b0;
    bus.pal_we    = 1'b0;
    bus.pal_addr  = 4'd0;
    bus.pal_data  = 12'h000;
    test_reset();
    test_exact_match();
    test_full_search();
    test_tie();
    test_backpressure();
    test_write_and_pixel();
    test_key_color();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
